// File: rtl/alu_pipe_top.sv
// Registered ALU with valid/ready handshakes: 16 logic functions, add/sub,
// shifts, and an iterative shift-add unsigned multiply.
module alu_pipe_top #(
   parameter  int ALU_WIDTH = 32,
   localparam int SHW       = $clog2(ALU_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ALU_WIDTH-1:0] opA,
   input  logic [ALU_WIDTH-1:0] opB,
   input  logic [3:0]           S,
   input  logic                 M,
   input  logic                 Cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ALU_WIDTH-1:0] DO,
   output logic                 C,
   output logic                 V,
   output logic                 N,
   output logic                 Z,
   output logic                 ERR
);

   localparam int W = ALU_WIDTH;

   localparam logic [3:0] OP_SHL = 4'b0011;
   localparam logic [3:0] OP_SHR = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_ADD = 4'b1001;
   localparam logic [3:0] OP_MUL = 4'b1100;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [2*W-1:0]   mcand_q, mcand_d;
   logic [W-1:0]     mplier_q, mplier_d;
   logic [2*W-1:0]   acc_q, acc_d, acc_step;
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     do_q, do_d;
   logic             c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d, err_q, err_d;

   logic             accept, retire, out_free, is_mul, mul_last;
   logic [SHW-1:0]   sh;
   logic [W:0]       sum_ext, dif_ext, shl_ext, shr_ext;
   logic signed [W:0] sra_ext;
   logic [W-1:0]     res_do;
   logic             res_c, res_v, res_err;

   assign out_free = !out_valid_q || out_ready;
   assign in_ready = (state_q == IDLE) && out_free;
   assign accept   = in_valid && in_ready;
   assign retire   = out_valid_q && out_ready;
   assign is_mul   = M && (S == OP_MUL);
   assign mul_last = (state_q == BUSY) && (cnt_q == SHW'(W - 1));
   assign sh       = opB[SHW-1:0];

   // The extra bit on each shift captures the last bit shifted out (0 for sh=0).
   assign sum_ext  = {1'b0, opA} + {1'b0, opB} + {{W{1'b0}}, Cin};
   assign dif_ext  = {1'b0, opA} + {1'b0, ~opB} + {{W{1'b0}}, Cin};
   assign shl_ext  = {1'b0, opA} << sh;
   assign shr_ext  = {opA, 1'b0} >> sh;
   assign sra_ext  = $signed({opA, 1'b0}) >>> sh;
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      res_do  = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      res_err = 1'b0;
      if (!M) begin
         res_c = Cin;
         case (S)
            4'b0000: res_do = '0;
            4'b0001: res_do = ~(opA | opB);
            4'b0010: res_do = ~opA & opB;
            4'b0011: res_do = ~opA;
            4'b0100: res_do = opA & ~opB;
            4'b0101: res_do = ~opB;
            4'b0110: res_do = opA ^ opB;
            4'b0111: res_do = ~(opA & opB);
            4'b1000: res_do = opA & opB;
            4'b1001: res_do = ~(opA ^ opB);
            4'b1010: res_do = opB;
            4'b1011: res_do = ~opA | opB;
            4'b1100: res_do = opA;
            4'b1101: res_do = opA | ~opB;
            4'b1110: res_do = opA | opB;
            default: res_do = '1;
         endcase
      end else begin
         case (S)
            OP_ADD: begin
               res_do = sum_ext[W-1:0];
               res_c  = sum_ext[W];
               res_v  = (opA[W-1] == opB[W-1]) && (sum_ext[W-1] != opA[W-1]);
            end
            OP_SUB: begin
               res_do = dif_ext[W-1:0];
               res_c  = ~dif_ext[W];
               res_v  = (opA[W-1] != opB[W-1]) && (dif_ext[W-1] != opA[W-1]);
            end
            OP_SHL: begin
               res_do = shl_ext[W-1:0];
               res_c  = shl_ext[W];
            end
            OP_SHR: begin
               res_do = shr_ext[W:1];
               res_c  = shr_ext[0];
            end
            OP_SRA: begin
               res_do = sra_ext[W:1];
               res_c  = sra_ext[0];
            end
            OP_MUL: ;
            default: res_err = 1'b1;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q && !retire;
      do_d        = do_q;
      c_d         = c_q;
      v_d         = v_q;
      n_d         = n_q;
      z_d         = z_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (accept && is_mul) begin
               state_d  = BUSY;
               cnt_d    = '0;
               mcand_d  = {{W{1'b0}}, opA};
               mplier_d = opB;
               acc_d    = '0;
            end else if (accept) begin
               out_valid_d = 1'b1;
               do_d        = res_do;
               c_d         = res_c;
               v_d         = res_v;
               n_d         = res_do[W-1];
               z_d         = (res_do == '0);
               err_d       = res_err;
            end
         end
         BUSY: begin
            // The final step stalls until a still-held result has retired.
            if (!mul_last || out_free) begin
               acc_d    = acc_step;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + SHW'(1);
               if (mul_last) begin
                  state_d     = IDLE;
                  cnt_d       = '0;
                  out_valid_d = 1'b1;
                  do_d        = acc_step[W-1:0];
                  c_d         = |acc_step[2*W-1:W];
                  v_d         = |acc_step[2*W-1:W];
                  n_d         = acc_step[W-1];
                  z_d         = (acc_step[W-1:0] == '0);
                  err_d       = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         do_q        <= '0;
         c_q         <= 1'b0;
         v_q         <= 1'b0;
         n_q         <= 1'b0;
         z_q         <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         do_q        <= do_d;
         c_q         <= c_d;
         v_q         <= v_d;
         n_q         <= n_d;
         z_q         <= z_d;
         err_q       <= err_d;
      end
   end

   // NOTE: multiply operand/accumulator flops carry no reset; every MUL accept reloads them.
   always_ff @(posedge clk) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
   end

   assign out_valid = out_valid_q;
   assign DO        = do_q;
   assign C         = c_q;
   assign V         = v_q;
   assign N         = n_q;
   assign Z         = z_q;
   assign ERR       = err_q;

endmodule

// File: tb/tb_alu_pipe_top.sv
// Self-checking bench: a 32-bit and an 8-bit alu_pipe_top side by side, a
// scoreboard per instance, a hand-computed vector table and corner sequences.
module tb_alu_pipe_top;

   typedef struct packed {
      logic [31:0] dout;
      logic        c, v, n, z, err;
   } res_t;

   typedef struct packed {
      logic        d;
      logic [31:0] a, b;
      logic [3:0]  s;
      logic        m, cin;
      res_t        exp;
   } vec_t;

   typedef struct packed {
      logic        in_ready, out_valid;
      logic [31:0] dout;
      logic        c, v, n, z, err;
   } obs_t;

   logic        clk, rst_n;
   logic [31:0] a_s, b_s;
   logic [3:0]  s_s;
   logic        m_s, cin_s;
   logic        in_valid_v  [2];
   logic        out_ready_v [2];

   logic        rdy32, ov32, c32, v32, n32, z32, err32;
   logic [31:0] do32;
   logic        rdy8, ov8, c8, v8, n8, z8, err8;
   logic [7:0]  do8;
   obs_t        obs [2];

   int          checks = 0;
   int          errors = 0;
   res_t        sb0 [$];
   res_t        sb1 [$];
   vec_t        tbl [$];
   res_t        exp_m, got_m;

   alu_pipe_top #(.ALU_WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(rdy32),
      .opA(a_s), .opB(b_s), .S(s_s), .M(m_s), .Cin(cin_s),
      .out_valid(ov32), .out_ready(out_ready_v[0]), .DO(do32),
      .C(c32), .V(v32), .N(n32), .Z(z32), .ERR(err32)
   );

   alu_pipe_top #(.ALU_WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(rdy8),
      .opA(a_s[7:0]), .opB(b_s[7:0]), .S(s_s), .M(m_s), .Cin(cin_s),
      .out_valid(ov8), .out_ready(out_ready_v[1]), .DO(do8),
      .C(c8), .V(v8), .N(n8), .Z(z8), .ERR(err8)
   );

   assign obs[0] = {rdy32, ov32, do32, c32, v32, n32, z32, err32};
   assign obs[1] = {rdy8, ov8, {24'b0, do8}, c8, v8, n8, z8, err8};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wid(input int d);
      return (d == 0) ? 32 : 8;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Reference model on 64-bit integers; logic functions use S as a minterm table.
   function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] s, input logic m, input logic cin);
      longint mask, half, ua, ub, sa, sb, r, t, ts;
      logic   c, v, err;
      int     sh;
      res_t   res;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      sa   = (ua >= half) ? ua - 2 * half : ua;
      sb   = (ub >= half) ? ub - 2 * half : ub;
      sh   = int'(ub % w);
      r = 0; c = 1'b0; v = 1'b0; err = 1'b0;
      if (!m) begin
         for (int i = 0; i < w; i++) r[i] = s[{a[i], b[i]}];
         c = cin;
      end else begin
         case (s)
            4'b1001: begin
               t  = ua + ub + longint'(cin);
               r  = t & mask;
               c  = t[w];
               ts = sa + sb + longint'(cin);
               v  = (ts >= half) || (ts < -half);
            end
            4'b0110: begin
               t  = ua + longint'(cin) - ub - 1;
               r  = t & mask;
               c  = (ua + longint'(cin)) < (ub + 1);
               ts = sa - sb - 1 + longint'(cin);
               v  = (ts >= half) || (ts < -half);
            end
            4'b0011: begin r = (ua << sh) & mask;  c = (sh == 0) ? 1'b0 : ua[w - sh]; end
            4'b0100: begin r = ua >> sh;           c = (sh == 0) ? 1'b0 : ua[sh - 1]; end
            4'b0101: begin r = (sa >>> sh) & mask; c = (sh == 0) ? 1'b0 : ua[sh - 1]; end
            4'b1100: begin
               t = ua * ub;
               r = t & mask;
               c = ((t >> w) != 0);
               v = c;
            end
            default: err = 1'b1;
         endcase
      end
      res.dout = r[31:0];
      res.c    = c;
      res.v    = v;
      res.n    = r[w - 1];
      res.z    = (r == 0);
      res.err  = err;
      return res;
   endfunction

   function automatic vec_t mk(input logic d, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] s, input logic m, input logic cin,
                               input logic [31:0] dout, input logic c, input logic v,
                               input logic n, input logic z, input logic err);
      return {d, a, b, s, m, cin, dout, c, v, n, z, err};
   endfunction

   task automatic push(input int d, input res_t r);
      if (d == 0) sb0.push_back(r);
      else        sb1.push_back(r);
   endtask

   // Drive one request and wait (bounded) for it to be accepted.
   task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] s, input logic m, input logic cin, input res_t exp);
      int n;
      n = 0;
      a_s = a; b_s = b; s_s = s; m_s = m; cin_s = cin;
      in_valid_v[d] = 1'b1;
      @(negedge clk);
      while (!obs[d].in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check($sformatf("accept_timeout_w%0d", wid(d)), 64'(obs[d].in_ready), 64'd1);
      else          push(d, exp);
      @(posedge clk);
      #1;
      in_valid_v[d] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb0.size() != 0 || sb1.size() != 0) && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (n >= 500) check("drain_timeout", 64'(sb0.size() + sb1.size()), 64'd0);
   endtask

   task automatic check_reset(input int d);
      check($sformatf("rst_out_valid_w%0d", wid(d)), 64'(obs[d].out_valid), 64'd0);
      check($sformatf("rst_do_w%0d", wid(d)), 64'(obs[d].dout), 64'd0);
      check($sformatf("rst_flags_w%0d", wid(d)),
            64'({obs[d].c, obs[d].v, obs[d].n, obs[d].z, obs[d].err}), 64'd0);
      check($sformatf("rst_in_ready_w%0d", wid(d)), 64'(obs[d].in_ready), 64'd1);
   endtask

   task automatic mul_latency(input int d, input logic [31:0] a, input logic [31:0] b);
      int   cnt;
      logic rdy_seen;
      cnt = 0;
      rdy_seen = 1'b0;
      issue(d, a, b, 4'b1100, 1'b1, 1'b0, model(wid(d), a, b, 4'b1100, 1'b1, 1'b0));
      while (!obs[d].out_valid && cnt < 200) begin
         if (obs[d].in_ready) rdy_seen = 1'b1;
         @(posedge clk);
         #1;
         cnt++;
      end
      check($sformatf("mul_latency_w%0d", wid(d)), 64'(cnt), 64'(wid(d)));
      check($sformatf("mul_busy_in_ready_w%0d", wid(d)), 64'(rdy_seen), 64'd0);
   endtask

   task automatic backpressure(input int d, input logic [31:0] a1, input logic [31:0] b1,
                               input logic [31:0] a2, input logic [31:0] b2);
      res_t e1, e2;
      e1 = model(wid(d), a1, b1, 4'b1110, 1'b0, 1'b0);
      e2 = model(wid(d), a2, b2, 4'b1001, 1'b1, 1'b0);
      out_ready_v[d] = 1'b0;
      issue(d, a1, b1, 4'b1110, 1'b0, 1'b0, e1);
      a_s = a2; b_s = b2; s_s = 4'b1001; m_s = 1'b1; cin_s = 1'b0;
      in_valid_v[d] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("bp_in_ready_w%0d", wid(d)), 64'(obs[d].in_ready), 64'd0);
         check($sformatf("bp_do_stable_w%0d", wid(d)), 64'(obs[d].dout), 64'(e1.dout));
      end
      @(posedge clk);
      #1;
      out_ready_v[d] = 1'b1;
      @(negedge clk);
      check($sformatf("bp_in_ready_release_w%0d", wid(d)), 64'(obs[d].in_ready), 64'd1);
      push(d, e2);
      @(posedge clk);
      #1;
      in_valid_v[d] = 1'b0;
      check($sformatf("bp_valid_held_w%0d", wid(d)), 64'(obs[d].out_valid), 64'd1);
      check($sformatf("bp_new_do_w%0d", wid(d)), 64'(obs[d].dout), 64'(e2.dout));
   endtask

   // Scoreboard: compare every retired result with the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            if (obs[d].out_valid && out_ready_v[d]) begin
               if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                  check($sformatf("unexpected_out_w%0d", wid(d)), 64'(obs[d].out_valid), 64'd0);
               end else begin
                  if (d == 0) exp_m = sb0.pop_front();
                  else        exp_m = sb1.pop_front();
                  got_m = {obs[d].dout, obs[d].c, obs[d].v, obs[d].n, obs[d].z, obs[d].err};
                  check($sformatf("result_w%0d", wid(d)), 64'(got_m), 64'(exp_m));
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] ra, rb;
      logic        rc;
      logic        seen;

      //              d  A             B             S      M  Cin DO            C  V  N  Z  ERR
      tbl.push_back(mk(0, 32'hffff0000, 32'hff00ff00, 4'h6, 0, 1, 32'h00ffff00, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 32'h7fffffff, 32'h7aaaaaaa, 4'h9, 1, 0, 32'hfaaaaaa9, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 32'hffffffff, 32'h00000001, 4'h9, 1, 0, 32'h00000000, 1, 0, 0, 1, 0));
      tbl.push_back(mk(0, 32'h00000001, 32'h00000002, 4'h6, 1, 1, 32'hffffffff, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 32'h80000000, 32'h00000001, 4'h6, 1, 1, 32'h7fffffff, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 32'h80000000, 32'h00000004, 4'h5, 1, 0, 32'hf8000000, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 32'h00010000, 32'h00010000, 4'hc, 1, 0, 32'h00000000, 1, 1, 0, 1, 0));
      tbl.push_back(mk(0, 32'h0000ffff, 32'h0000ffff, 4'hc, 1, 0, 32'hfffe0001, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 32'h12345678, 32'h9abcdef0, 4'h0, 1, 1, 32'h00000000, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 32'h80000001, 32'h00000001, 4'h3, 1, 0, 32'h00000002, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 32'h00000003, 32'h00000001, 4'h4, 1, 0, 32'h00000001, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 32'h12345678, 32'h00000020, 4'h3, 1, 1, 32'h12345678, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 32'h00000000, 32'h00000000, 4'hf, 0, 0, 32'hffffffff, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 32'h000000f0, 32'h000000cc, 4'h6, 0, 1, 32'h0000003c, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 32'h0000007f, 32'h0000007a, 4'h9, 1, 0, 32'h000000f9, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 32'h000000ff, 32'h00000001, 4'h9, 1, 0, 32'h00000000, 1, 0, 0, 1, 0));
      tbl.push_back(mk(1, 32'h00000001, 32'h00000002, 4'h6, 1, 1, 32'h000000ff, 1, 0, 1, 0, 0));
      tbl.push_back(mk(1, 32'h0000007f, 32'h00000001, 4'h6, 1, 0, 32'h0000007d, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 32'h00000080, 32'h00000004, 4'h5, 1, 0, 32'h000000f8, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 32'h00000010, 32'h00000010, 4'hc, 1, 0, 32'h00000000, 1, 1, 0, 1, 0));
      tbl.push_back(mk(1, 32'h0000000f, 32'h0000000f, 4'hc, 1, 0, 32'h000000e1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 32'h0000005a, 32'h00000033, 4'h0, 1, 0, 32'h00000000, 0, 0, 0, 1, 1));
      tbl.push_back(mk(1, 32'h00000081, 32'h00000009, 4'h3, 1, 0, 32'h00000002, 1, 0, 0, 0, 0));

      rst_n = 1'b0;
      a_s = '0; b_s = '0; s_s = '0; m_s = 1'b0; cin_s = 1'b0;
      in_valid_v[0] = 1'b0;  in_valid_v[1] = 1'b0;
      out_ready_v[0] = 1'b1; out_ready_v[1] = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_reset(0);
      check_reset(1);
      @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++)
         issue(int'(tbl[i].d), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].m, tbl[i].cin, tbl[i].exp);
      drain();

      // Full logic table on operands that cover every (a,b) bit pair.
      for (int s = 0; s < 16; s++) begin
         issue(0, 32'hffff0000, 32'hff00ff00, 4'(s), 1'b0, s[0],
               model(32, 32'hffff0000, 32'hff00ff00, 4'(s), 1'b0, s[0]));
         issue(1, 32'h000000f0, 32'h000000cc, 4'(s), 1'b0, s[1],
               model(8, 32'h000000f0, 32'h000000cc, 4'(s), 1'b0, s[1]));
      end
      drain();

      for (int d = 0; d < 2; d++) begin
         for (int m = 0; m < 2; m++) begin
            for (int s = 0; s < 16; s++) begin
               ra = $urandom;
               rb = $urandom;
               rc = 1'($urandom_range(0, 1));
               issue(d, ra, rb, 4'(s), 1'(m), rc, model(wid(d), ra, rb, 4'(s), 1'(m), rc));
            end
         end
      end
      drain();

      mul_latency(0, 32'h00010000, 32'h00010000);
      mul_latency(1, 32'h000000d3, 32'h000000b7);
      drain();

      backpressure(0, 32'h0f0f0000, 32'h000000f0, 32'h7fffffff, 32'h00000001);
      drain();
      backpressure(1, 32'h00000030, 32'h00000005, 32'h00000080, 32'h00000080);
      drain();

      // Reset in the middle of a multiply: nothing from it may reach the output.
      issue(0, 32'h0000ffff, 32'h0000ffff, 4'hc, 1'b1, 1'b0,
            model(32, 32'h0000ffff, 32'h0000ffff, 4'hc, 1'b1, 1'b0));
      issue(1, 32'h0000000f, 32'h0000000f, 4'hc, 1'b1, 1'b0,
            model(8, 32'h0000000f, 32'h0000000f, 4'hc, 1'b1, 1'b0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      sb0.delete();
      sb1.delete();
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_reset(0);
      check_reset(1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ov32 || ov8) seen = 1'b1;
      end
      check("abort_no_output", 64'(seen), 64'd0);

      @(posedge clk);
      #1;
      issue(0, 32'h00000005, 32'h00000003, 4'h9, 1'b1, 1'b1,
            model(32, 32'h00000005, 32'h00000003, 4'h9, 1'b1, 1'b1));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
